// File: rtl/wiener_stats_ctrl_mc_pkg.sv
// wiener_pkg: shared state encoding and helpers for the Wiener
// block-statistics control path.
package wiener_pkg;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WAIT,
        ISSUE,
        DRAIN,
        DONE
    } wiener_stats_state_t;

    function automatic int clamp_log2(
        input int v,
        input int max_log2
    );
        if (v < 1) begin
            return 1;
        end
        if (v > max_log2) begin
            return max_log2;
        end
        return v;
    endfunction

endpackage

// File: rtl/wiener_stats_ctrl_mc_if.sv
// Stream, configuration and result-join signals between the pixel
// front end, the per-channel statistics units and the controller.
interface wiener_stats_ctrl_mc_if #(
    parameter int NUM_CHANNELS      = 3,
    parameter int MAX_BLOCK_SAMPLES = 64,
    parameter int BLK_CNT_WIDTH     = 32
);
    localparam int BSL_W = $clog2(MAX_BLOCK_SAMPLES) + 1;

    logic                     start_of_frame;
    logic                     in_valid;
    logic                     in_ready;
    logic [BSL_W-1:0]         block_size_log2;
    logic [BLK_CNT_WIDTH-1:0] blocks_per_frame;
    logic [NUM_CHANNELS-1:0]  mean_ready;
    logic [NUM_CHANNELS-1:0]  variance_ready;
    logic                     shift_en_in;
    logic                     shift_en_out;
    logic                     shift_en_mean;
    logic                     variance_start;
    logic                     buf_rst_n;
    logic                     frame_done;
    logic                     frame_abort;

    modport master (
        output start_of_frame,
        output in_valid,
        output block_size_log2,
        output blocks_per_frame,
        output mean_ready,
        output variance_ready,
        input  in_ready,
        input  shift_en_in,
        input  shift_en_out,
        input  shift_en_mean,
        input  variance_start,
        input  buf_rst_n,
        input  frame_done,
        input  frame_abort
    );

    modport slave (
        input  start_of_frame,
        input  in_valid,
        input  block_size_log2,
        input  blocks_per_frame,
        input  mean_ready,
        input  variance_ready,
        output in_ready,
        output shift_en_in,
        output shift_en_out,
        output shift_en_mean,
        output variance_start,
        output buf_rst_n,
        output frame_done,
        output frame_abort
    );

endinterface

// File: rtl/wiener_stats_ctrl_mc_join.sv
// wiener_ready_join: sticky per-channel done flags; all_seen also
// counts pulses arriving in the current cycle.
module wiener_ready_join #(
    parameter int NUM_CHANNELS = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr,
    input  logic [NUM_CHANNELS-1:0] pulse,
    output logic                    all_seen
);
    logic [NUM_CHANNELS-1:0] flags_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q <= '0;
        end else if (clr) begin
            flags_q <= '0;
        end else begin
            flags_q <= flags_q | pulse;
        end
    end

    assign all_seen = &(flags_q | pulse);

endmodule

// File: rtl/wiener_stats_ctrl_mc.sv
// wiener_stats_ctrl_mc: per-block sequencer for the Wiener statistics
// stage, serving all colour channels from one FSM.
module wiener_stats_ctrl_mc
    import wiener_pkg::*;
#(
    parameter int NUM_CHANNELS      = 3,
    parameter int MAX_BLOCK_SAMPLES = 64,
    parameter int BLK_CNT_WIDTH     = 32
) (
    input logic                   clk,
    input logic                   rst_n,
    wiener_stats_ctrl_mc_if.slave bus
);
    localparam int LOG2_MAX = $clog2(MAX_BLOCK_SAMPLES);
    localparam int SMP_W    = LOG2_MAX + 1;
    localparam int BW       = BLK_CNT_WIDTH;

    wiener_stats_state_t state_q, state_d;

    logic [SMP_W-1:0] smp_q, smp_d, smp_nx;
    logic [SMP_W-1:0] n_q, n_d, cfg_n;
    logic [BW-1:0]    blk_q, blk_d, blk_nx;
    logic [BW-1:0]    b_q, b_d, cfg_b;
    logic             go_q, go_d;

    logic rdy, accept, sof;
    logic [NUM_CHANNELS-1:0] mean_p, var_p;
    logic mean_all, var_all;
    logic mean_clr, var_clr;
    logic sei, seo, sem, vst;
    logic brn, fdone, fabort;

    assign rdy    = (state_q == IDLE) || (state_q == READ);
    assign accept = bus.in_valid && rdy;
    assign sof    = bus.start_of_frame;
    assign smp_nx = smp_q + SMP_W'(1);
    assign blk_nx = blk_q + BW'(1);

    assign cfg_n = SMP_W'(1) << clamp_log2(
        int'(bus.block_size_log2), LOG2_MAX);
    assign cfg_b = (bus.blocks_per_frame == '0) ?
        BW'(1) : bus.blocks_per_frame;

    // Result pulses only count in the state that waits for them.
    assign mean_p = (state_q == WAIT)  ? bus.mean_ready     : '0;
    assign var_p  = (state_q == DRAIN) ? bus.variance_ready : '0;

    wiener_ready_join #(.NUM_CHANNELS(NUM_CHANNELS)) u_mean_join (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (mean_clr),
        .pulse    (mean_p),
        .all_seen (mean_all)
    );

    wiener_ready_join #(.NUM_CHANNELS(NUM_CHANNELS)) u_var_join (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (var_clr),
        .pulse    (var_p),
        .all_seen (var_all)
    );

    always_comb begin
        state_d  = state_q;
        smp_d    = smp_q;
        n_d      = n_q;
        blk_d    = blk_q;
        b_d      = b_q;
        go_d     = go_q;
        sei      = 1'b0;
        seo      = 1'b0;
        sem      = 1'b0;
        vst      = 1'b0;
        brn      = 1'b1;
        fdone    = 1'b0;
        fabort   = 1'b0;
        mean_clr = 1'b0;
        var_clr  = 1'b0;
        unique case (state_q)
            IDLE: begin
                brn = 1'b0;
                if (accept && sof) begin
                    sei     = 1'b1;
                    n_d     = cfg_n;
                    b_d     = cfg_b;
                    smp_d   = SMP_W'(1);
                    blk_d   = '0;
                    go_d    = 1'b0;
                    state_d = READ;
                end
            end
            READ: begin
                if (accept) begin
                    sei = 1'b1;
                    seo = (blk_q != '0);
                end
                if (accept && sof) begin
                    // Restart: the sample opens the new frame.
                    fabort   = 1'b1;
                    brn      = 1'b0;
                    n_d      = cfg_n;
                    b_d      = cfg_b;
                    smp_d    = SMP_W'(1);
                    blk_d    = '0;
                    go_d     = 1'b0;
                    mean_clr = 1'b1;
                    var_clr  = 1'b1;
                end else if (accept) begin
                    if (smp_nx == n_q) begin
                        smp_d   = '0;
                        state_d = WAIT;
                    end else begin
                        smp_d = smp_nx;
                    end
                end
            end
            WAIT: begin
                if (mean_all) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                sem      = 1'b1;
                vst      = 1'b1;
                mean_clr = 1'b1;
                var_clr  = 1'b1;
                blk_d    = blk_nx;
                state_d  = (blk_nx == b_q) ? DRAIN : READ;
            end
            DRAIN: begin
                if (go_q) begin
                    seo = 1'b1;
                    if (smp_q == n_q - SMP_W'(1)) begin
                        smp_d   = '0;
                        go_d    = 1'b0;
                        state_d = DONE;
                    end else begin
                        smp_d = smp_nx;
                    end
                end else if (var_all) begin
                    go_d = 1'b1;
                end
            end
            DONE: begin
                fdone   = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            smp_q   <= '0;
            n_q     <= '0;
            blk_q   <= '0;
            b_q     <= '0;
            go_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            smp_q   <= smp_d;
            n_q     <= n_d;
            blk_q   <= blk_d;
            b_q     <= b_d;
            go_q    <= go_d;
        end
    end

    assign bus.in_ready       = rdy;
    assign bus.shift_en_in    = sei;
    assign bus.shift_en_out   = seo;
    assign bus.shift_en_mean  = sem;
    assign bus.variance_start = vst;
    assign bus.buf_rst_n      = brn;
    assign bus.frame_done     = fdone;
    assign bus.frame_abort    = fabort;

endmodule

// File: tb/tb_wiener_stats_ctrl_mc.sv
// Bench for wiener_stats_ctrl_mc: vector table for a basic frame,
// directed corner sequences and randomized frames vs a frame model.
module tb_wiener_stats_ctrl_mc;
    localparam int NC   = 3;
    localparam int MAXS = 64;
    localparam int BW   = 32;
    localparam int LOGM = 6;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    wiener_stats_ctrl_mc_if #(
        .NUM_CHANNELS(NC),
        .MAX_BLOCK_SAMPLES(MAXS),
        .BLK_CNT_WIDTH(BW)
    ) bus ();

    wiener_stats_ctrl_mc #(
        .NUM_CHANNELS(NC),
        .MAX_BLOCK_SAMPLES(MAXS),
        .BLK_CNT_WIDTH(BW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        bit         sof;
        bit         vld;
        logic [2:0] mr;
        logic [2:0] vr;
        logic [7:0] exp;
    } vec_t;

    vec_t tbl[$];
    int n_chk = 0;
    int n_err = 0;
    logic s_ir, s_sei, s_seo, s_sem, s_vs, s_brn, s_fd, s_fa;
    int cnt_in, cnt_out_acc, cnt_out_drn, cnt_mean, cnt_done;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] outs();
        return {s_ir, s_sei, s_seo, s_sem, s_vs, s_brn, s_fd, s_fa};
    endfunction

    task automatic sample();
        s_ir  = bus.in_ready;
        s_sei = bus.shift_en_in;
        s_seo = bus.shift_en_out;
        s_sem = bus.shift_en_mean;
        s_vs  = bus.variance_start;
        s_brn = bus.buf_rst_n;
        s_fd  = bus.frame_done;
        s_fa  = bus.frame_abort;
        if (s_sei) cnt_in++;
        if (s_seo && s_sei) cnt_out_acc++;
        if (s_seo && !s_sei) cnt_out_drn++;
        if (s_sem) cnt_mean++;
        if (s_fd) cnt_done++;
    endtask

    // Inputs are set at posedge+1; outputs are sampled at the negedge.
    task automatic cyc();
        #4;
        sample();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_cnt();
        cnt_in = 0;
        cnt_out_acc = 0;
        cnt_out_drn = 0;
        cnt_mean = 0;
        cnt_done = 0;
    endtask

    task automatic set_cfg(input int bsl, input int bpf);
        bus.block_size_log2  = 7'(bsl);
        bus.blocks_per_frame = 32'(bpf);
    endtask

    function automatic int model_n(input int bsl);
        int l;
        l = bsl;
        if (l < 1) l = 1;
        if (l > LOGM) l = LOGM;
        return 1 << l;
    endfunction

    function automatic void add(bit s, bit v, logic [2:0] m,
                                logic [2:0] r, logic [7:0] e);
        vec_t x;
        x.sof = s;
        x.vld = v;
        x.mr  = m;
        x.vr  = r;
        x.exp = e;
        tbl.push_back(x);
    endfunction

    task automatic feed(input int k, input bit sof_first, input int pct,
                        input bit exp_out, input string tag);
        int got = 0;
        int bad = 0;
        int seo_n = 0;
        int guard = 0;
        while (got < k && guard < 4000) begin
            bus.in_valid = ($urandom_range(99) < pct);
            bus.start_of_frame = sof_first && got == 0 && bus.in_valid;
            cyc();
            if (bus.in_valid && s_ir) got++;
            if (s_sei != (bus.in_valid && s_ir)) bad++;
            if (s_sei && s_seo) seo_n++;
            if (s_fa) bad++;
            guard++;
        end
        bus.in_valid = 1'b0;
        bus.start_of_frame = 1'b0;
        chk({tag, " accepts"}, got, k);
        chk({tag, " accept/shift_in"}, bad, 0);
        chk({tag, " shift_out on accept"}, seo_n, exp_out ? k : 0);
    endtask

    task automatic join_res(input int d[NC], input bit is_var,
                            input string tag);
        int mx = 0;
        int bad = 0;
        logic [NC-1:0] p;
        for (int c = 0; c < NC; c++) if (d[c] > mx) mx = d[c];
        for (int t = 0; t <= mx; t++) begin
            for (int c = 0; c < NC; c++) p[c] = (d[c] == t);
            if (is_var) bus.variance_ready = p;
            else bus.mean_ready = p;
            bus.in_valid = 1'($urandom_range(1));
            cyc();
            if (s_ir || s_sei || s_sem || s_seo || s_vs) bad++;
        end
        bus.mean_ready = '0;
        bus.variance_ready = '0;
        bus.in_valid = 1'b0;
        chk({tag, " quiet while joining"}, bad, 0);
        if (!is_var) begin
            cyc();
            chk({tag, " issue pulse"}, int'({s_sem, s_vs, s_ir}), 6);
        end
    endtask

    task automatic drain(input int n, input string tag);
        int bad = 0;
        for (int i = 0; i < n; i++) begin
            cyc();
            if (!s_seo || s_sei || s_fd) bad++;
        end
        chk({tag, " drain shifts"}, bad, 0);
        cyc();
        chk({tag, " frame_done"}, int'({s_fd, s_seo}), 2);
        cyc();
        chk({tag, " back to idle"}, int'({s_ir, s_brn, s_fd}), 4);
    endtask

    task automatic rand_delays(output int d[NC]);
        for (int c = 0; c < NC; c++) d[c] = int'($urandom_range(4));
    endtask

    task automatic run_frame(input int bsl, input int bpf, input int pct,
                             input string tag);
        int n, b;
        int d[NC];
        n = model_n(bsl);
        b = (bpf < 1) ? 1 : bpf;
        clr_cnt();
        set_cfg(bsl, bpf);
        for (int k = 0; k < b; k++) begin
            feed(n, k == 0, pct, k > 0, tag);
            // Mid-frame configuration changes must not matter.
            set_cfg(int'($urandom_range(9)), int'($urandom_range(3)));
            rand_delays(d);
            join_res(d, 1'b0, tag);
        end
        rand_delays(d);
        join_res(d, 1'b1, tag);
        drain(n, tag);
        chk({tag, " total shift_in"}, cnt_in, n * b);
        chk({tag, " total mean pulses"}, cnt_mean, b);
        chk({tag, " total drain shifts"}, cnt_out_drn, n);
        chk({tag, " total frame_done"}, cnt_done, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d[NC];
        bus.start_of_frame = 1'b0;
        bus.in_valid = 1'b0;
        bus.mean_ready = '0;
        bus.variance_ready = '0;
        set_cfg(2, 2);
        clr_cnt();

        #2;
        sample();
        chk("reset outputs", int'(outs()), 8'b1000_0000);
        #10;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic frame N=4, B=2 cycle by cycle.
        add(1, 1, 0, 0, 8'b1100_0000);
        add(0, 1, 0, 0, 8'b1100_0100);
        add(0, 1, 0, 0, 8'b1100_0100);
        add(0, 1, 0, 0, 8'b1100_0100);
        add(0, 1, 7, 0, 8'b0000_0100);
        add(0, 1, 0, 0, 8'b0001_1100);
        for (int i = 0; i < 4; i++) add(0, 1, 0, 0, 8'b1110_0100);
        add(0, 0, 7, 0, 8'b0000_0100);
        add(0, 0, 0, 0, 8'b0001_1100);
        add(0, 1, 0, 7, 8'b0000_0100);
        for (int i = 0; i < 4; i++) add(0, 0, 0, 0, 8'b0010_0100);
        add(0, 0, 0, 0, 8'b0000_0110);
        add(0, 1, 0, 0, 8'b1000_0000);
        clr_cnt();
        foreach (tbl[i]) begin
            bus.start_of_frame = tbl[i].sof;
            bus.in_valid = tbl[i].vld;
            bus.mean_ready = tbl[i].mr;
            bus.variance_ready = tbl[i].vr;
            cyc();
            chk($sformatf("basic row %0d", i), int'(outs()),
                int'(tbl[i].exp));
        end
        bus.in_valid = 1'b0;
        bus.mean_ready = '0;
        bus.variance_ready = '0;
        chk("basic frame_done count", cnt_done, 1);
        chk("basic mean count", cnt_mean, 2);

        // Staggered mean join: channels at t, t+3, t+1.
        set_cfg(1, 1);
        feed(2, 1'b1, 100, 1'b0, "stagger");
        clr_cnt();
        d[0] = 0;
        d[1] = 3;
        d[2] = 1;
        join_res(d, 1'b0, "stagger");
        chk("stagger single mean pulse", cnt_mean, 1);
        rand_delays(d);
        join_res(d, 1'b1, "stagger var");
        drain(2, "stagger");

        // Backpressure: N=8, B=3, 50% valid.
        run_frame(3, 3, 50, "backpressure");
        chk("backpressure shift_out on accept", cnt_out_acc, 16);

        // Boundary configuration: B=0 -> 1, log2 9 -> 6.
        run_frame(9, 0, 100, "boundary");

        // Restart at sample 5 of block 1.
        set_cfg(3, 2);
        feed(8, 1'b1, 100, 1'b0, "restart b0");
        rand_delays(d);
        join_res(d, 1'b0, "restart b0");
        feed(4, 1'b0, 100, 1'b1, "restart b1");
        set_cfg(2, 1);
        bus.in_valid = 1'b1;
        bus.start_of_frame = 1'b1;
        cyc();
        chk("restart abort cycle", int'({s_fa, s_brn, s_sei}), 5);
        bus.in_valid = 1'b0;
        bus.start_of_frame = 1'b0;
        cyc();
        chk("restart after abort", int'({s_fa, s_brn, s_ir}), 3);
        feed(3, 1'b0, 100, 1'b0, "restart new");
        rand_delays(d);
        join_res(d, 1'b0, "restart new");
        rand_delays(d);
        join_res(d, 1'b1, "restart new var");
        drain(4, "restart new");

        // Asynchronous reset during DRAIN.
        set_cfg(2, 1);
        feed(4, 1'b1, 100, 1'b0, "rst");
        rand_delays(d);
        join_res(d, 1'b0, "rst");
        rand_delays(d);
        join_res(d, 1'b1, "rst var");
        cyc();
        chk("rst draining", int'(s_seo), 1);
        cyc();
        rst_n = 1'b0;
        #1;
        sample();
        chk("rst in drain outputs", int'(outs()), 8'b1000_0000);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b1;
        cyc();
        chk("idle drop without sof", int'({s_ir, s_sei, s_brn}), 4);
        bus.in_valid = 1'b0;
        run_frame(2, 1, 100, "post reset");

        // Randomized frames against the frame model.
        for (int i = 0; i < 6; i++) begin
            run_frame(int'($urandom_range(8)), int'($urandom_range(3)),
                      30 + int'($urandom_range(70)),
                      $sformatf("rand%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 n_chk, n_err);
        $finish;
    end

endmodule
